i2s_mix_scheduler: RTL and testbench

//  Frame scheduler and mixer that feeds i2s_tx with a stereo sample each frame.
//  On each i2s_tx ready pulse it polls NUM_VOICES voice generators round-robin from voice 0.
//  It sums their signed left/right samples and saturates them.
//  It presents the 64-bit {left,right} word on sample well before the next frame load.

---
 rtl/i2s_mix_scheduler_if.sv | 28 ++
 rtl/i2s_mix_scheduler.sv | 148 ++++++++++++++
 tb/tb_i2s_mix_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_mix_scheduler_if.sv
// Handshake and sample bus between the voice bank / i2s_tx side and the
// frame mixer. The mixer connects through the slave modport.
interface i2s_mix_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int VOICE_W    = 24
);
    logic                          enable;
    logic                          tx_ready;
    logic [NUM_VOICES-1:0]         voice_valid;
    logic [NUM_VOICES*VOICE_W-1:0] voice_left;
    logic [NUM_VOICES*VOICE_W-1:0] voice_right;
    logic [NUM_VOICES-1:0]         voice_ack;
    logic [63:0]                   sample;
    logic                          sample_ready;
    logic                          busy;
    logic [15:0]                   underrun_cnt;
    logic                          overrun;

    modport master (
        output enable, tx_ready, voice_valid, voice_left, voice_right,
        input  voice_ack, sample, sample_ready, busy, underrun_cnt, overrun
    );

    modport slave (
        input  enable, tx_ready, voice_valid, voice_left, voice_right,
        output voice_ack, sample, sample_ready, busy, underrun_cnt, overrun
    );
endinterface

// File: rtl/i2s_mix_scheduler.sv
// Frame scheduler/mixer for i2s_tx: on each tx_ready pulse it polls the
// voices round-robin, sums their signed samples, saturates, and presents a
// left-justified {left,right} word well before the next frame load.
module i2s_mix_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int VOICE_W    = 24
) (
    input logic                sclk,
    input logic                aclr,
    i2s_mix_scheduler_if.slave bus
);
    localparam int ACC_W = VOICE_W + 4;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {5'b00000, {(VOICE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {5'b11111, {(VOICE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SAT,
        PRESENT
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic [31:0]             res_l;
    logic [31:0]             res_r;
    logic [63:0]             sample_q;
    logic                    sample_ready_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic [15:0]             underrun_q;
    logic [NUM_VOICES-1:0]   ack;
    logic [VOICE_W-1:0]      cur_l;
    logic [VOICE_W-1:0]      cur_r;
    logic                    cur_valid;

    assign cur_l     = bus.voice_left[int'(idx)*VOICE_W +: VOICE_W];
    assign cur_r     = bus.voice_right[int'(idx)*VOICE_W +: VOICE_W];
    assign cur_valid = bus.voice_valid[idx];

    assign bus.voice_ack    = ack;
    assign bus.sample       = sample_q;
    assign bus.sample_ready = sample_ready_q;
    assign bus.busy         = busy_q;
    assign bus.underrun_cnt = underrun_q;
    assign bus.overrun      = overrun_q;

    // Clamp to the signed VOICE_W range, then left-justify into 32 bits.
    function automatic logic [31:0] clamp_justify(input logic signed [ACC_W-1:0] a);
        logic signed [VOICE_W-1:0] s;
        if (a > SAT_MAX)
            s = SAT_MAX[VOICE_W-1:0];
        else if (a < SAT_MIN)
            s = SAT_MIN[VOICE_W-1:0];
        else
            s = a[VOICE_W-1:0];
        return 32'(s) << (32 - VOICE_W);
    endfunction

    // State register.
    always_ff @(posedge sclk) begin
        if (aclr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state and voice ack decode; ack is suppressed during reset so an
    // aborted mix never consumes a voice sample.
    always_comb begin
        state_nx = state;
        ack      = '0;
        case (state)
            IDLE: begin
                if (bus.tx_ready && bus.enable)
                    state_nx = COLLECT;
            end
            COLLECT: begin
                if (cur_valid && !aclr)
                    ack[idx] = 1'b1;
                if (idx == LAST_IDX)
                    state_nx = SAT;
            end
            SAT:     state_nx = PRESENT;
            PRESENT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Mixing datapath, status flags and presented sample.
    always_ff @(posedge sclk) begin
        if (aclr) begin
            idx            <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            res_l          <= '0;
            res_r          <= '0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= '0;
        end else begin
            if (bus.tx_ready && busy_q)
                overrun_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.tx_ready) begin
                        if (bus.enable) begin
                            acc_l          <= '0;
                            acc_r          <= '0;
                            idx            <= '0;
                            busy_q         <= 1'b1;
                            sample_ready_q <= 1'b0;
                        end else begin
                            sample_q       <= '0;
                            sample_ready_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cur_valid) begin
                        acc_l <= acc_l + $signed({{4{cur_l[VOICE_W-1]}}, cur_l});
                        acc_r <= acc_r + $signed({{4{cur_r[VOICE_W-1]}}, cur_r});
                    end else if (underrun_q != 16'hFFFF) begin
                        underrun_q <= underrun_q + 16'd1;
                    end
                    idx <= idx + 1'b1;
                end
                SAT: begin
                    res_l <= clamp_justify(acc_l);
                    res_r <= clamp_justify(acc_r);
                end
                PRESENT: begin
                    sample_q       <= {res_l, res_r};
                    sample_ready_q <= 1'b1;
                    busy_q         <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_mix_scheduler.sv
// Self-checking bench for i2s_mix_scheduler: directed and random frames
// compared against an arithmetic mixing model.
module tb_i2s_mix_scheduler;
    localparam int NV = 4;
    localparam int W  = 24;

    logic sclk = 1'b0;
    logic aclr = 1'b1;
    always #5 sclk = ~sclk;

    i2s_mix_scheduler_if #(.NUM_VOICES(NV), .VOICE_W(W)) bif ();
    i2s_mix_scheduler #(.NUM_VOICES(NV), .VOICE_W(W)) dut (
        .sclk(sclk),
        .aclr(aclr),
        .bus (bif.slave)
    );

    int checks = 0;
    int failures = 0;
    int vl[NV];
    int vr[NV];
    int exp_underrun = 0;
    int obs_lat;
    logic obs_busy0;
    logic [NV*8-1:0] obs_acks;

    // Expected frame word: plain integer sum, clamp, scale to 32-bit left-justified.
    function automatic logic [63:0] model_mix(input logic [NV-1:0] v);
        longint sl = 0;
        longint sr = 0;
        longint hi = (longint'(1) << (W - 1)) - 1;
        longint lo = -(longint'(1) << (W - 1));
        for (int i = 0; i < NV; i++)
            if (v[i]) begin
                sl += vl[i];
                sr += vr[i];
            end
        if (sl > hi) sl = hi;
        if (sl < lo) sl = lo;
        if (sr > hi) sr = hi;
        if (sr < lo) sr = lo;
        return {32'(sl * (longint'(1) << (32 - W))), 32'(sr * (longint'(1) << (32 - W)))};
    endfunction

    // Expected ack per cycle after acceptance: voice k acked in cycle k only if valid.
    function automatic logic [NV*8-1:0] exp_acks(input logic [NV-1:0] v);
        logic [NV*8-1:0] r = '0;
        for (int k = 0; k < NV; k++)
            if (v[k]) r[k*NV +: NV] = NV'(1) << k;
        return r;
    endfunction

    task automatic load_voices(input logic [NV-1:0] v);
        bif.voice_valid = v;
        for (int i = 0; i < NV; i++) begin
            bif.voice_left[i*W +: W]  = vl[i][W-1:0];
            bif.voice_right[i*W +: W] = vr[i][W-1:0];
        end
    endtask

    // Pulse tx_ready, then record acks per cycle until sample_ready rises (bounded).
    task automatic capture(input int extra_tx_k, input int en_drop_k);
        @(negedge sclk);
        bif.tx_ready = 1'b1;
        @(negedge sclk);
        bif.tx_ready = 1'b0;
        obs_lat   = -1;
        obs_acks  = '0;
        obs_busy0 = bif.busy;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) obs_acks[k*NV +: NV] = bif.voice_ack;
            if (bif.sample_ready) begin
                obs_lat = k;
                break;
            end
            bif.tx_ready = (k == extra_tx_k);
            if (k == en_drop_k) bif.enable = 1'b0;
            @(negedge sclk);
        end
        bif.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        bif.enable = 1'b1;
        bif.tx_ready = 1'b0;
        bif.voice_valid = '0;
        bif.voice_left = '0;
        bif.voice_right = '0;
        repeat (3) @(negedge sclk);
        checks++; if (bif.sample !== 64'd0) begin failures++; $display("FAIL reset_sample got=%h exp=0", bif.sample); end
        checks++; if (bif.sample_ready !== 1'b0) begin failures++; $display("FAIL reset_sample_ready got=%b exp=0", bif.sample_ready); end
        checks++; if (bif.voice_ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bif.voice_ack); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
        checks++; if (bif.underrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_underrun got=%0d exp=0", bif.underrun_cnt); end
        checks++; if (bif.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bif.overrun); end
        aclr = 1'b0;
        exp_underrun = 0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < NV; i++) begin
            vl[i] = i + 1;
            vr[i] = -(i + 1);
        end
        load_voices(4'b1111);
        capture(-1, -1);
        checks++; if (obs_lat != NV + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", obs_lat, NV + 2); end
        checks++; if (obs_busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", obs_busy0); end
        checks++; if (obs_acks !== exp_acks(4'b1111)) begin failures++; $display("FAIL basic_acks got=%h exp=%h", obs_acks, exp_acks(4'b1111)); end
        checks++; if (bif.sample !== 64'h00000A00_FFFFF600) begin failures++; $display("FAIL basic_sample got=%h exp=%h", bif.sample, 64'h00000A00_FFFFF600); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < NV; i++) begin
            vl[i] = 8388607;
            vr[i] = -8388608;
        end
        load_voices(4'b1111);
        capture(-1, -1);
        checks++; if (obs_lat != NV + 2) begin failures++; $display("FAIL sat_latency got=%0d exp=%0d", obs_lat, NV + 2); end
        checks++; if (bif.sample !== 64'h7FFFFF00_80000000) begin failures++; $display("FAIL sat_sample got=%h exp=%h", bif.sample, 64'h7FFFFF00_80000000); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < NV; i++) begin
            vl[i] = i + 1;
            vr[i] = 100 * (i + 1);
        end
        load_voices(4'b1010);
        capture(-1, -1);
        exp_underrun += 2;
        checks++; if (obs_acks !== exp_acks(4'b1010)) begin failures++; $display("FAIL under_acks got=%h exp=%h", obs_acks, exp_acks(4'b1010)); end
        checks++; if (bif.underrun_cnt !== 16'(exp_underrun)) begin failures++; $display("FAIL under_cnt got=%0d exp=%0d", bif.underrun_cnt, exp_underrun); end
        checks++; if (bif.sample !== model_mix(4'b1010)) begin failures++; $display("FAIL under_sample got=%h exp=%h", bif.sample, model_mix(4'b1010)); end
    endtask

    task automatic test_random();
        logic [NV-1:0] v;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    vl[i] = 8388607 - int'($urandom_range(0, 15));
                    vr[i] = -8388608 + int'($urandom_range(0, 15));
                end else begin
                    vl[i] = int'($urandom_range(0, 16777215)) - 8388608;
                    vr[i] = int'($urandom_range(0, 16777215)) - 8388608;
                end
            end
            v = NV'($urandom);
            load_voices(v);
            capture(-1, -1);
            exp_underrun += NV - $countones(v);
            checks++; if (obs_lat != NV + 2) begin failures++; $display("FAIL rand_latency f=%0d got=%0d exp=%0d", f, obs_lat, NV + 2); end
            checks++; if (obs_acks !== exp_acks(v)) begin failures++; $display("FAIL rand_acks f=%0d got=%h exp=%h", f, obs_acks, exp_acks(v)); end
            checks++; if (bif.sample !== model_mix(v)) begin failures++; $display("FAIL rand_sample f=%0d got=%h exp=%h", f, bif.sample, model_mix(v)); end
            checks++; if (bif.underrun_cnt !== 16'(exp_underrun)) begin failures++; $display("FAIL rand_underrun f=%0d got=%0d exp=%0d", f, bif.underrun_cnt, exp_underrun); end
        end
    endtask

    task automatic test_overrun();
        int extra;
        for (int i = 0; i < NV; i++) begin
            vl[i] = 1000 * (i + 1);
            vr[i] = -7 * (i + 1);
        end
        load_voices(4'b1111);
        capture(2, -1);
        checks++; if (bif.overrun !== 1'b1) begin failures++; $display("FAIL over_flag got=%b exp=1", bif.overrun); end
        checks++; if (obs_acks !== exp_acks(4'b1111)) begin failures++; $display("FAIL over_acks got=%h exp=%h", obs_acks, exp_acks(4'b1111)); end
        checks++; if (bif.sample !== model_mix(4'b1111)) begin failures++; $display("FAIL over_sample got=%h exp=%h", bif.sample, model_mix(4'b1111)); end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sclk);
            if (bif.voice_ack !== '0 || bif.busy !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL over_no_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_mute();
        int extra;
        bif.enable = 1'b0;
        load_voices(4'b1111);
        capture(-1, -1);
        checks++; if (obs_lat != 0) begin failures++; $display("FAIL mute_ready got=%0d exp=0", obs_lat); end
        checks++; if (bif.sample !== 64'd0) begin failures++; $display("FAIL mute_sample got=%h exp=0", bif.sample); end
        checks++; if (obs_busy0 !== 1'b0) begin failures++; $display("FAIL mute_busy got=%b exp=0", obs_busy0); end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (bif.voice_ack !== '0 || bif.busy !== 1'b0) extra++;
            @(negedge sclk);
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL mute_no_ack got=%0d exp=0", extra); end
        checks++; if (bif.underrun_cnt !== 16'(exp_underrun)) begin failures++; $display("FAIL mute_underrun got=%0d exp=%0d", bif.underrun_cnt, exp_underrun); end
        bif.enable = 1'b1;
    endtask

    task automatic test_enable_fall();
        for (int i = 0; i < NV; i++) begin
            vl[i] = -3000 * (i + 1);
            vr[i] = 55 + i;
        end
        load_voices(4'b1111);
        capture(-1, 1);
        checks++; if (obs_lat != NV + 2) begin failures++; $display("FAIL efall_latency got=%0d exp=%0d", obs_lat, NV + 2); end
        checks++; if (bif.sample !== model_mix(4'b1111)) begin failures++; $display("FAIL efall_sample got=%h exp=%h", bif.sample, model_mix(4'b1111)); end
        capture(-1, -1);
        checks++; if (bif.sample !== 64'd0 || obs_lat != 0) begin failures++; $display("FAIL efall_next got=%h lat=%0d exp=0 lat=0", bif.sample, obs_lat); end
        bif.enable = 1'b1;
    endtask

    task automatic test_abort();
        int extra;
        for (int i = 0; i < NV; i++) begin
            vl[i] = 12345 + i;
            vr[i] = -54321 - i;
        end
        load_voices(4'b1111);
        @(negedge sclk);
        bif.tx_ready = 1'b1;
        @(negedge sclk);
        bif.tx_ready = 1'b0;
        checks++; if (bif.voice_ack !== 4'b0001) begin failures++; $display("FAIL abort_ack0 got=%b exp=0001", bif.voice_ack); end
        @(negedge sclk);
        checks++; if (bif.voice_ack !== 4'b0010) begin failures++; $display("FAIL abort_ack1 got=%b exp=0010", bif.voice_ack); end
        @(negedge sclk);
        aclr = 1'b1;
        #1;
        checks++; if (bif.voice_ack !== 4'b0000) begin failures++; $display("FAIL abort_ack2 got=%b exp=0000", bif.voice_ack); end
        @(negedge sclk);
        checks++;
        if (bif.sample !== 64'd0 || bif.sample_ready !== 1'b0 || bif.busy !== 1'b0 ||
            bif.underrun_cnt !== 16'd0 || bif.overrun !== 1'b0 || bif.voice_ack !== '0) begin
            failures++;
            $display("FAIL abort_outputs got=%h/%b/%b/%0d/%b/%b exp=all zero",
                     bif.sample, bif.sample_ready, bif.busy, bif.underrun_cnt, bif.overrun, bif.voice_ack);
        end
        aclr = 1'b0;
        exp_underrun = 0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sclk);
            if (bif.voice_ack !== '0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL abort_no_late_ack got=%0d exp=0", extra); end
        capture(-1, -1);
        checks++; if (obs_acks !== exp_acks(4'b1111)) begin failures++; $display("FAIL abort_next_acks got=%h exp=%h", obs_acks, exp_acks(4'b1111)); end
        checks++; if (bif.sample !== model_mix(4'b1111)) begin failures++; $display("FAIL abort_next_sample got=%h exp=%h", bif.sample, model_mix(4'b1111)); end
        checks++; if (bif.underrun_cnt !== 16'(exp_underrun)) begin failures++; $display("FAIL abort_next_underrun got=%0d exp=%0d", bif.underrun_cnt, exp_underrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_underrun();
        test_random();
        test_overrun();
        test_mute();
        test_enable_fall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
